// File: rtl/debug_slave_pkg.sv
// Shared constants and helpers for the system-clock debug slave command queue.
package debug_slave_pkg;

   localparam int unsigned IR_OCIMEM          = 0;
   localparam int unsigned IR_TRACE           = 1;
   localparam int unsigned IR_BREAK           = 2;
   localparam int unsigned IR_TRACECTRL       = 3;

   localparam int unsigned DR_W_DEFAULT       = 38;
   localparam int unsigned ACTION_BIT_DEFAULT = 34;

   // Index width for a table of n entries, never narrower than one bit.
   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/debug_slave_event_sync.sv
// Multi-flop synchroniser for a TCK-domain level followed by a registered rising-edge detector.
module debug_slave_event_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic async_in,
   output logic evt
);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   prev_q, prev_d;
   logic                   evt_q, evt_d;

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
      prev_d = sync_q[SYNC_STAGES-1];
      evt_d  = sync_q[SYNC_STAGES-1] & ~prev_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q <= '0;
         prev_q <= 1'b0;
         evt_q  <= 1'b0;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
         evt_q  <= evt_d;
      end
   end

   assign evt = evt_q;

endmodule

// File: rtl/debug_slave_sysclk_cmdq.sv
// CPU-clock half of the debug slave: synchronised JTAG update strobes feed a command FIFO
// drained over valid/ready, with per-IR action decode. Optional stats: DEBUG_SLAVE_CMDQ_STATS_EN.
module debug_slave_sysclk_cmdq
   import debug_slave_pkg::*;
#(
   parameter int unsigned IR_W         = 2,
   parameter int unsigned DR_W         = DR_W_DEFAULT,
   parameter int unsigned ACTION_BIT   = ACTION_BIT_DEFAULT,
   parameter int unsigned SYNC_STAGES  = 2,
   parameter int unsigned FIFO_DEPTH   = 4,
   parameter int unsigned FLUSH_ON_UIR = 1
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        vs_udr,
   input  logic                        vs_uir,
   input  logic [IR_W-1:0]             ir_in,
   input  logic [DR_W-1:0]             sr,
   input  logic                        cmd_ready,
   output logic                        cmd_valid,
   output logic [IR_W-1:0]             cmd_ir,
   output logic [DR_W-1:0]             cmd_data,
   output logic [DR_W-1:0]             jdo,
   output logic [(1<<IR_W)-1:0]        take_action,
   output logic [(1<<IR_W)-1:0]        take_no_action,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level,
   output logic                        overflow
`ifdef DEBUG_SLAVE_CMDQ_STATS_EN
   ,
   output logic [15:0]                 accept_count,
   output logic [15:0]                 drop_count
`endif
);

   localparam int unsigned NUM_IR = 1 << IR_W;
   localparam int unsigned PTR_W  = clog2_min1(FIFO_DEPTH);
   localparam int unsigned ENT_W  = IR_W + DR_W;
   localparam logic [PTR_W:0] PTR_ONE = (PTR_W+1)'(1);

   logic udr_evt, uir_evt;

   debug_slave_event_sync #(.SYNC_STAGES(SYNC_STAGES)) u_udr_sync (
      .clk      (clk),
      .reset    (reset),
      .async_in (vs_udr),
      .evt      (udr_evt)
   );

   debug_slave_event_sync #(.SYNC_STAGES(SYNC_STAGES)) u_uir_sync (
      .clk      (clk),
      .reset    (reset),
      .async_in (vs_uir),
      .evt      (uir_evt)
   );

   logic [ENT_W-1:0]  mem_q [FIFO_DEPTH];
   logic [PTR_W:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [DR_W-1:0]   jdo_q, jdo_d;
   logic [NUM_IR-1:0] ta_q, ta_d, tna_q, tna_d;
   logic              overflow_q, overflow_d;

   logic              empty_c, full_c, flush_c, accept_c, do_write_c, drop_c;
   logic [ENT_W-1:0]  head_c;
   logic [IR_W-1:0]   head_ir_c;
   logic [DR_W-1:0]   head_data_c;

   assign head_c = mem_q[rd_ptr_q[PTR_W-1:0]];

   // A flush clears the queue before any same-cycle write, so that write always lands.
   always_comb begin
      empty_c     = (wr_ptr_q == rd_ptr_q);
      full_c      = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                    (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
      flush_c     = (FLUSH_ON_UIR != 0) && uir_evt;
      accept_c    = !empty_c && cmd_ready && !flush_c;
      do_write_c  = udr_evt && (flush_c || !full_c || accept_c);
      drop_c      = udr_evt && !do_write_c;
      head_ir_c   = head_c[ENT_W-1:DR_W];
      head_data_c = head_c[DR_W-1:0];

      rd_ptr_d    = rd_ptr_q;
      wr_ptr_d    = wr_ptr_q;
      jdo_d       = jdo_q;
      ta_d        = '0;
      tna_d       = '0;
      overflow_d  = overflow_q | drop_c;

      if (flush_c) begin
         rd_ptr_d = wr_ptr_q;
      end else if (accept_c) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      if (do_write_c) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (accept_c) begin
         jdo_d = head_data_c;
         if (head_data_c[ACTION_BIT]) begin
            ta_d = NUM_IR'(1) << head_ir_c;
         end else begin
            tna_d = NUM_IR'(1) << head_ir_c;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         jdo_q      <= '0;
         ta_q       <= '0;
         tna_q      <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         jdo_q      <= jdo_d;
         ta_q       <= ta_d;
         tna_q      <= tna_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage needs no reset: entries are only visible between the pointers.
   always_ff @(posedge clk) begin
      if (do_write_c) begin
         mem_q[wr_ptr_q[PTR_W-1:0]] <= {ir_in, sr};
      end
   end

   assign cmd_valid      = !empty_c;
   assign cmd_ir         = empty_c ? '0 : head_ir_c;
   assign cmd_data       = empty_c ? '0 : head_data_c;
   assign jdo            = jdo_q;
   assign take_action    = ta_q;
   assign take_no_action = tna_q;
   assign fifo_level     = wr_ptr_q - rd_ptr_q;
   assign overflow       = overflow_q;

`ifdef DEBUG_SLAVE_CMDQ_STATS_EN
   logic [15:0] acc_cnt_q, acc_cnt_d, drop_cnt_q, drop_cnt_d;

   // Accept count wraps; drop count saturates.
   always_comb begin
      acc_cnt_d  = accept_c ? acc_cnt_q + 16'd1 : acc_cnt_q;
      drop_cnt_d = (drop_c && (drop_cnt_q != 16'hFFFF)) ? drop_cnt_q + 16'd1 : drop_cnt_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         acc_cnt_q  <= '0;
         drop_cnt_q <= '0;
      end else begin
         acc_cnt_q  <= acc_cnt_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign accept_count = acc_cnt_q;
   assign drop_count   = drop_cnt_q;
`endif

endmodule

// File: tb/tb_debug_slave_sysclk_cmdq.sv
// Self-checking bench for debug_slave_sysclk_cmdq: directed scenarios plus random traffic against a queue model.
module tb_debug_slave_sysclk_cmdq;

   localparam int unsigned IR_W        = 2;
   localparam int unsigned DR_W        = 38;
   localparam int unsigned ACTION_BIT  = 34;
   localparam int unsigned SYNC_STAGES = 2;
   localparam int unsigned FIFO_DEPTH  = 4;
   localparam int unsigned NUM_IR      = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              reset, vs_udr, vs_uir, cmd_ready;
   logic [IR_W-1:0]   ir_in;
   logic [DR_W-1:0]   sr;
   logic              cmd_valid, overflow;
   logic [IR_W-1:0]   cmd_ir;
   logic [DR_W-1:0]   cmd_data, jdo;
   logic [NUM_IR-1:0] take_action, take_no_action;
   logic [2:0]        fifo_level;
`ifdef DEBUG_SLAVE_CMDQ_STATS_EN
   logic [15:0]       accept_count, drop_count;
`endif

   debug_slave_sysclk_cmdq #(
      .IR_W(IR_W), .DR_W(DR_W), .ACTION_BIT(ACTION_BIT),
      .SYNC_STAGES(SYNC_STAGES), .FIFO_DEPTH(FIFO_DEPTH), .FLUSH_ON_UIR(1)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .vs_udr         (vs_udr),
      .vs_uir         (vs_uir),
      .ir_in          (ir_in),
      .sr             (sr),
      .cmd_ready      (cmd_ready),
      .cmd_valid      (cmd_valid),
      .cmd_ir         (cmd_ir),
      .cmd_data       (cmd_data),
      .jdo            (jdo),
      .take_action    (take_action),
      .take_no_action (take_no_action),
      .fifo_level     (fifo_level),
      .overflow       (overflow)
`ifdef DEBUG_SLAVE_CMDQ_STATS_EN
      ,
      .accept_count   (accept_count),
      .drop_count     (drop_count)
`endif
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference model: an update level seen at edge n becomes a queue event at edge n+SYNC_STAGES+1.
   typedef struct {
      logic [IR_W-1:0] ir;
      logic [DR_W-1:0] data;
   } cmd_t;

   cmd_t              mq[$];
   bit                udr_hist[$];
   bit                uir_hist[$];
   logic [DR_W-1:0]   m_jdo;
   logic [NUM_IR-1:0] m_ta, m_tna;
   bit                m_ovf;
   int                m_acc, m_drop;
   bit                started = 1'b0;

   always @(posedge clk) begin
      bit   ue, ie, acc;
      cmd_t h;
      if (reset) begin
         mq.delete();
         udr_hist.delete();
         uir_hist.delete();
         repeat (SYNC_STAGES + 2) begin
            udr_hist.push_back(1'b0);
            uir_hist.push_back(1'b0);
         end
         m_jdo = '0; m_ta = '0; m_tna = '0; m_ovf = 1'b0; m_acc = 0; m_drop = 0;
         started = 1'b1;
      end else if (started) begin
         ue = udr_hist[1] && !udr_hist[0];
         ie = uir_hist[1] && !uir_hist[0];
         void'(udr_hist.pop_front());
         void'(uir_hist.pop_front());
         udr_hist.push_back(vs_udr);
         uir_hist.push_back(vs_uir);
         m_ta = '0; m_tna = '0; acc = 1'b0;
         if (ie) mq.delete();
         else if (mq.size() > 0 && cmd_ready) begin
            h = mq.pop_front();
            acc = 1'b1;
         end
         if (acc) begin
            m_jdo = h.data;
            m_acc = (m_acc + 1) % 65536;
            if (h.data[ACTION_BIT]) m_ta[h.ir] = 1'b1;
            else                    m_tna[h.ir] = 1'b1;
         end
         if (ue) begin
            if (mq.size() < FIFO_DEPTH) mq.push_back('{ir_in, sr});
            else begin
               m_ovf = 1'b1;
               if (m_drop < 65535) m_drop++;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (started) begin
         chk("cmd_valid", cmd_valid, mq.size() > 0);
         chk("fifo_level", fifo_level, mq.size());
         if (mq.size() > 0) begin
            chk("cmd_ir", cmd_ir, mq[0].ir);
            chk("cmd_data", cmd_data, mq[0].data);
         end else begin
            chk("cmd_ir_empty", cmd_ir, 0);
            chk("cmd_data_empty", cmd_data, 0);
         end
         chk("jdo", jdo, m_jdo);
         chk("take_action", take_action, m_ta);
         chk("take_no_action", take_no_action, m_tna);
         chk("overflow", overflow, m_ovf);
`ifdef DEBUG_SLAVE_CMDQ_STATS_EN
         chk("accept_count", accept_count, m_acc);
         chk("drop_count", drop_count, m_drop);
`endif
      end
   end

   task automatic send_cmd(input logic [IR_W-1:0] ir, input logic [DR_W-1:0] data);
      ir_in  = ir;
      sr     = data;
      vs_udr = 1'b1;
      repeat (4) @(negedge clk);
      vs_udr = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; vs_udr = 1'b0; vs_uir = 1'b0; cmd_ready = 1'b0; ir_in = '0; sr = '0;
      repeat (3) @(negedge clk);
      chk("rst_valid", cmd_valid, 0);
      chk("rst_level", fifo_level, 0);
      chk("rst_jdo", jdo, 0);

      // Single command: latency and take_action decode.
      reset = 1'b0;
      ir_in = 2'd0; sr = 38'h4_0000_1234; vs_udr = 1'b1;
      repeat (3) @(negedge clk);
      chk("lat_early", cmd_valid, 0);
      @(negedge clk);
      chk("lat_valid", cmd_valid, 1);
      chk("lat_data", cmd_data, 38'h4_0000_1234);
      cmd_ready = 1'b1; vs_udr = 1'b0;
      @(negedge clk);
      chk("ta_ocimem", take_action, 4'b0001);
      chk("jdo_first", jdo, 38'h4_0000_1234);
      cmd_ready = 1'b0;
      @(negedge clk);
      chk("ta_one_cycle", take_action, 4'b0000);

      // No-action decode on IR 2.
      send_cmd(2'd2, 38'h0_0000_00AA);
      chk("na_level", fifo_level, 1);
      cmd_ready = 1'b1;
      @(negedge clk);
      chk("tna_break", take_no_action, 4'b0100);
      chk("tna_ta_zero", take_action, 4'b0000);
      cmd_ready = 1'b0;
      @(negedge clk);
      chk("tna_one_cycle", take_no_action, 4'b0000);

      // Backpressure: five commands into a four-deep queue, then drain in order.
      for (int i = 1; i <= 5; i++) send_cmd(IR_W'(i % 4), DR_W'(i));
      chk("bp_level", fifo_level, 4);
      chk("bp_overflow", overflow, 1);
`ifdef DEBUG_SLAVE_CMDQ_STATS_EN
      chk("bp_drops", drop_count, 1);
`endif
      cmd_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         chk("drain_jdo", jdo, i);
      end
      cmd_ready = 1'b0;
      @(negedge clk);
      chk("drain_empty", cmd_valid, 0);

      // Full queue with an accept in the write cycle.
      do_reset();
      for (int i = 0; i < 4; i++) send_cmd(IR_W'(i), DR_W'(16 + i));
      ir_in = 2'd1; sr = 38'h55; vs_udr = 1'b1;
      repeat (3) @(negedge clk);
      cmd_ready = 1'b1;
      @(negedge clk);
      cmd_ready = 1'b0;
      chk("full_acc_level", fifo_level, 4);
      chk("full_acc_ovf", overflow, 0);
      vs_udr = 1'b0;
      repeat (2) @(negedge clk);

      // Flush together with a new command leaves only the new one.
      do_reset();
      for (int i = 0; i < 3; i++) send_cmd(IR_W'(i), DR_W'(32 + i));
      ir_in = 2'd1; sr = 38'hABC; vs_udr = 1'b1; vs_uir = 1'b1;
      repeat (4) @(negedge clk);
      chk("flush_level", fifo_level, 1);
      chk("flush_data", cmd_data, 38'hABC);
      chk("flush_ir", cmd_ir, 1);
      vs_udr = 1'b0; vs_uir = 1'b0;
      repeat (2) @(negedge clk);

      // Reset mid-queue with an accept request and the update level held high.
      do_reset();
      send_cmd(2'd3, 38'h4_0000_0011);
      send_cmd(2'd0, 38'h22);
      ir_in = 2'd2; sr = 38'h77; vs_udr = 1'b1;
      @(negedge clk);
      reset = 1'b1; cmd_ready = 1'b1;
      @(negedge clk);
      chk("mid_rst_valid", cmd_valid, 0);
      chk("mid_rst_level", fifo_level, 0);
      chk("mid_rst_ta", take_action, 0);
      chk("mid_rst_tna", take_no_action, 0);
      reset = 1'b0; cmd_ready = 1'b0;
      repeat (6) @(negedge clk);
      chk("mid_rst_one", fifo_level, 1);
      chk("mid_rst_data", cmd_data, 38'h77);
      vs_udr = 1'b0;
      repeat (2) @(negedge clk);

      // Random traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(2) == 0) vs_udr = ~vs_udr;
         if ($urandom_range(15) == 0) vs_uir = ~vs_uir;
         cmd_ready = ($urandom_range(2) != 0);
         ir_in = IR_W'($urandom);
         sr = DR_W'({$urandom, $urandom});
         reset = ($urandom_range(199) == 0);
         @(negedge clk);
      end
      reset = 1'b0;
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/debug_slave_sysclk_cmdq.md
Name: debug_slave_sysclk_cmdq

Overview:
- Parametrised successor to the system-clock half of the Nios debug slave.
- Brings JTAG update-DR/update-IR strobes into the CPU clock domain through a configurable synchroniser.
- Queues each captured debug command (IR code plus DR data) in a small FIFO, so back-to-back JTAG commands are not lost.
- Presents commands to the OCI core over a valid/ready handshake and decodes per-IR take_action / take_no_action pulses for any IR width.

Parameters:
- IR_W, 2: JTAG instruction width; the block decodes NUM_IR = 2**IR_W codes.
- DR_W, 38: data-register (sr/jdo) width.
- ACTION_BIT, 34: bit of the data word that selects take_action (1) or take_no_action (0); must be < DR_W.
- SYNC_STAGES, 2: synchroniser flop count, must be >= 2.
- FIFO_DEPTH, 4: command queue depth, must be a power of two and >= 2.
- FLUSH_ON_UIR, 1: 1 means an update-IR event discards queued, unaccepted commands.

Ports:
- clk, in, 1: CPU system clock.
- reset, in, 1: synchronous, active-high reset.
- vs_udr, in, 1: virtual update-DR level from the TCK domain; asynchronous to clk.
- vs_uir, in, 1: virtual update-IR level from the TCK domain; asynchronous to clk.
- ir_in, in, IR_W: current JTAG IR; quasi-static around vs_udr.
- sr, in, DR_W: TCK-domain shift register; quasi-static around vs_udr.
- cmd_ready, in, 1: core accepts the head command.
- cmd_valid, out, 1: a head command is available.
- cmd_ir, out, IR_W: IR code of the head command.
- cmd_data, out, DR_W: data of the head command.
- jdo, out, DR_W: data of the last accepted command, held until the next accept.
- take_action, out, NUM_IR: one-hot, one-cycle pulse.
- take_no_action, out, NUM_IR: one-hot, one-cycle pulse.
- fifo_level, out, $clog2(FIFO_DEPTH)+1: number of queued entries.
- overflow, out, 1: sticky flag; a command was dropped.

Behaviour:
- Reset:
  - Synchroniser and edge flops clear to 0.
  - FIFO empties and fifo_level = 0.
  - cmd_valid = 0, jdo = 0, take_action = 0, take_no_action = 0, overflow = 0.
  - cmd_ir and cmd_data read as 0 while the FIFO is empty.
- Synchroniser:
  - vs_udr and vs_uir each pass through SYNC_STAGES flops, then a rising-edge detector (one extra flop).
  - This produces single-cycle udr_evt and uir_evt.
  - A level already high when reset releases produces exactly one event.
- Enqueue: on udr_evt, write {ir_in, sr} into the FIFO, sampled in that same cycle.
- Latency: with an empty FIFO, vs_udr high at clk edge 0 gives cmd_valid = 1 after edge SYNC_STAGES+1.
- Handshake:
  - An accept occurs when cmd_valid && cmd_ready on a rising edge; the head is popped.
  - cmd_valid, cmd_ir and cmd_data are combinational from the FIFO head.
  - They must stay stable while cmd_valid && !cmd_ready.
- Decode, registered, in the cycle after an accept:
  - jdo <= accepted data.
  - take_action[k] = 1 if accepted ir == k and data[ACTION_BIT] == 1.
  - take_no_action[k] = 1 if accepted ir == k and data[ACTION_BIT] == 0.
  - All other bits are 0, and both vectors are all-zero in cycles without a prior accept.
- Full queue:
  - udr_evt while full with no accept in that cycle: the command is dropped, overflow <= 1, and fifo_level stays at FIFO_DEPTH.
  - udr_evt while full with an accept in the same cycle: the write succeeds.
- Empty queue: cmd_ready is ignored and there is no pop.
- Pointer wrap: read and write pointers carry one extra bit; full and empty are derived from pointer compare.
- Update-IR flush (FLUSH_ON_UIR=1):
  - uir_evt discards all entries, including the head; no accept is credited that cycle, even if cmd_ready = 1.
  - uir_evt and udr_evt in the same cycle: flush first, then write, leaving fifo_level = 1.
  - With FLUSH_ON_UIR=0, uir_evt has no effect.
- Reset mid-operation: queued commands are lost, and a pulse in flight does not appear after reset.

Optional Feature:
- Macro: DEBUG_SLAVE_CMDQ_STATS_EN.
- When defined, two extra outputs exist:
  - accept_count[15:0]: wraps; increments once per accept.
  - drop_count[15:0]: saturates at 16'hFFFF; increments once per dropped udr_evt; flushed entries are not counted as drops.
  - Both reset to 0.
- When undefined, these ports and their counters do not exist; all other behaviour is identical.

Decomposition:
- Package debug_slave_pkg holds:
  - IR code constants: IR_OCIMEM=0, IR_TRACE=1, IR_BREAK=2, IR_TRACECTRL=3.
  - Default widths: DR_W=38, ACTION_BIT=34.
  - Function clog2_min1.
- Sub-module debug_slave_event_sync: SYNC_STAGES-deep synchroniser plus rising-edge detect, with clk/reset/async_in/evt ports. It is instantiated twice, once for vs_udr and once for vs_uir.
- The FIFO stays inline.

Test Plan:
- Single command: ir_in=0, sr[34]=1, sr=38'h4_0000_1234, vs_udr pulse, cmd_ready=1 → cmd_valid after edge 3; next cycle take_action=4'b0001, jdo=38'h4_0000_1234.
- No-action decode: ir_in=2, sr[34]=0 → take_no_action=4'b0100 for exactly one cycle, take_action=0.
- Backpressure: cmd_ready=0, 5 udr pulses (FIFO_DEPTH=4) → fifo_level=4, overflow=1, drop_count=1; then drain → accepts 4 commands in order with data 1..4.
- Full with simultaneous accept: full FIFO, cmd_ready=1 in the udr_evt cycle → fifo_level stays 4, overflow stays 0.
- Flush: 3 entries queued, then vs_uir and vs_udr rising together → fifo_level=1, and the head carries the new sr.
- Reset mid-queue: 2 entries queued, vs_udr held high, reset for 1 cycle → all outputs 0, then exactly one command is enqueued after release.
